nonogram_line_solver: RTL

NONOGRAM_LINE_SOLVER -- requirements
Module: nonogram_line_solver

---
 rtl/nonogram_line_solver_if.sv | 21 ++
 rtl/nonogram_line_solver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nonogram_line_solver_if.sv
// Option word handshake between the option FIFO and the line solver.
// Master drives option words; slave accepts them when ready.
interface nonogram_line_solver_if #(
  parameter int MAX_SIZE = 11
);
  logic [MAX_SIZE-1:0] option;
  logic                option_valid;
  logic                option_ready;

  modport master (
    output option,
    output option_valid,
    input  option_ready
  );

  modport slave (
    input  option,
    input  option_valid,
    output option_ready
  );
endinterface

// File: rtl/nonogram_line_solver.sv
// Nonogram line solver: filters candidate options of one line and commits
// the cells they agree on. Define NONOGRAM_CONTRADICTION_EN for error flagging.
module nonogram_line_solver #(
  parameter int MAX_SIZE = 11,
  parameter int CNT_W    = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            started,
  input  logic [3:0]                      num_rows,
  input  logic [3:0]                      num_cols,
  input  logic [2*MAX_SIZE*CNT_W-1:0]     old_options_amnt,
  nonogram_line_solver_if.slave           opt_if,
  output logic                            new_line,
  output logic                            put_back_to_FIFO,
  output logic                            put_back_valid,
  output logic                            line_done,
  output logic [CNT_W-1:0]                new_options_amnt,
  output logic [MAX_SIZE*MAX_SIZE-1:0]    known,
  output logic [MAX_SIZE*MAX_SIZE-1:0]    assigned,
  output logic                            solved,
  output logic                            error
);

  localparam int GW = MAX_SIZE * MAX_SIZE;
  localparam int NL = 2 * MAX_SIZE;
  localparam int KW = $clog2(NL);
  localparam logic [CNT_W-1:0] SAT = '1;

  typedef enum logic [1:0] {
    IDX,
    OPT,
    COMMIT
  } state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    surv_q, surv_d;
  logic [MAX_SIZE-1:0] and_q, and_d;
  logic [MAX_SIZE-1:0] or_q, or_d;
  logic [GW-1:0]       known_q, known_d;
  logic [GW-1:0]       asg_q, asg_d;
  logic                solved_q, solved_d;
  logic                error_q, error_d;
  logic                ready_q, ready_d;
  logic                new_line_q, new_line_d;
  logic                pbv_q, pbv_d;
  logic                pbf_q, pbf_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    amnt_q, amnt_d;

  int                  kk, col, len, raw;
  logic                is_row, line_ok;
  logic [MAX_SIZE-1:0] in_line, line_k, line_a;
  int                  idx_a [MAX_SIZE];
  logic                consistent;
  logic [CNT_W-1:0]    sel_n;
  logic [GW-1:0]       active;
  logic                all_known;

  // Map each cell of the current line onto its grid bit.
  always_comb begin
    kk      = int'(k_q);
    is_row  = kk < int'(num_rows);
    col     = kk - int'(num_rows);
    line_ok = is_row || (col < int'(num_cols));
    len     = is_row ? int'(num_cols) : int'(num_rows);
    raw     = 0;
    in_line = '0;
    line_k  = '0;
    line_a  = '0;
    for (int i = 0; i < MAX_SIZE; i++) begin
      raw = is_row ? kk * MAX_SIZE + i : i * MAX_SIZE + col;
      in_line[i] = line_ok && (i < len) && (raw >= 0) && (raw < GW);
      idx_a[i]   = in_line[i] ? raw : 0;
      line_k[i]  = known_q[idx_a[i]];
      line_a[i]  = asg_q[idx_a[i]];
    end
  end

  assign consistent =
    ~|(in_line & line_k & (opt_if.option ^ line_a));

  always_comb begin
    sel_n = '0;
    for (int j = 0; j < NL; j++) begin
      if (opt_if.option[KW-1:0] == KW'(j))
        sel_n = old_options_amnt[CNT_W*j +: CNT_W];
    end
  end

  always_comb begin
    active = '0;
    for (int r = 0; r < MAX_SIZE; r++) begin
      for (int c = 0; c < MAX_SIZE; c++) begin
        if (r < int'(num_rows) && c < int'(num_cols))
          active[r*MAX_SIZE+c] = 1'b1;
      end
    end
  end

  assign all_known = &(known_q | ~active);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    surv_d     = surv_q;
    and_d      = and_q;
    or_d       = or_q;
    known_d    = known_q;
    asg_d      = asg_q;
    solved_d   = all_known;
    error_d    = error_q;
    amnt_d     = amnt_q;
    pbv_d      = 1'b0;
    pbf_d      = pbf_q;
    done_d     = 1'b0;
    new_line_d = 1'b0;

    unique case (state_q)
      IDX: begin
        if (opt_if.option_valid) begin
          k_d     = opt_if.option[KW-1:0];
          n_d     = sel_n;
          cnt_d   = '0;
          surv_d  = '0;
          and_d   = '1;
          or_d    = '0;
          state_d = (sel_n != '0) ? OPT : COMMIT;
        end
      end
      OPT: begin
        if (opt_if.option_valid) begin
          pbv_d = 1'b1;
          pbf_d = consistent;
          if (consistent) begin
            surv_d = (surv_q == SAT) ? surv_q : surv_q + 1'b1;
            and_d  = and_q & opt_if.option;
            or_d   = or_q | opt_if.option;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == n_q) state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (surv_q != '0) begin
          for (int i = 0; i < MAX_SIZE; i++) begin
            if (in_line[i] && and_q[i]) begin
              known_d[idx_a[i]] = 1'b1;
              asg_d[idx_a[i]]   = 1'b1;
            end else if (in_line[i] && !or_q[i]) begin
              known_d[idx_a[i]] = 1'b1;
              asg_d[idx_a[i]]   = 1'b0;
            end
          end
        end
`ifdef NONOGRAM_CONTRADICTION_EN
        if (surv_q == '0 && n_q != '0) error_d = 1'b1;
`else
        error_d = 1'b0;
`endif
        state_d = IDX;
      end
      default: state_d = IDX;
    endcase

    // Line-end pulses are registered so they sit on the COMMIT cycle.
    if (state_d == COMMIT && state_q != COMMIT) begin
      done_d     = 1'b1;
      new_line_d = 1'b1;
      amnt_d     = surv_d;
    end

    ready_d = (state_d != COMMIT);

    if (started) begin
      state_d    = IDX;
      known_d    = '0;
      asg_d      = '0;
      solved_d   = 1'b0;
      error_d    = 1'b0;
      ready_d    = 1'b1;
      pbv_d      = 1'b0;
      done_d     = 1'b0;
      new_line_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDX;
      k_q        <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      surv_q     <= '0;
      and_q      <= '1;
      or_q       <= '0;
      known_q    <= '0;
      asg_q      <= '0;
      solved_q   <= 1'b0;
      error_q    <= 1'b0;
      ready_q    <= 1'b1;
      new_line_q <= 1'b0;
      pbv_q      <= 1'b0;
      pbf_q      <= 1'b0;
      done_q     <= 1'b0;
      amnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      surv_q     <= surv_d;
      and_q      <= and_d;
      or_q       <= or_d;
      known_q    <= known_d;
      asg_q      <= asg_d;
      solved_q   <= solved_d;
      error_q    <= error_d;
      ready_q    <= ready_d;
      new_line_q <= new_line_d;
      pbv_q      <= pbv_d;
      pbf_q      <= pbf_d;
      done_q     <= done_d;
      amnt_q     <= amnt_d;
    end
  end

  assign opt_if.option_ready = ready_q;
  assign new_line            = new_line_q;
  assign put_back_valid      = pbv_q;
  assign put_back_to_FIFO    = pbf_q;
  assign line_done           = done_q;
  assign new_options_amnt    = amnt_q;
  assign known               = known_q;
  assign assigned            = asg_q;
  assign solved              = solved_q;
  assign error               = error_q;

endmodule
